// File: rtl/mem_burst_reader_pkg.sv
// Shared definitions for the memory burst reader.
// Contents:
//   DEF_ADDR_W / DEF_DATA_W : default address and data widths (8 / 8)
//   LEN_W                   : width of the remaining-byte counter (ADDR_W+1, so 256 fits)
//   state_e                 : sequencer states IDLE, READ, DRAIN, DONE
//   fifo_entry_t            : one streamed element {data, idx, last} at default widths
package mem_burst_reader_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int LEN_W      = DEF_ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_ADDR_W-1:0] idx;
    logic                  last;
  } fifo_entry_t;

endpackage

// File: rtl/mem_burst_reader_if.sv
// Bus bundle between the burst reader, its memory bank and the downstream stage.
// Signals:
//   Address, MemRead   : reader -> memory (address, read enable)
//   ReadData           : memory -> reader (combinational read data)
//   Out_Valid, Out_Data, Out_Idx, Out_Last : reader -> downstream stream
//   Out_Ready          : downstream -> reader
// Stream handshake: a beat transfers on a rising edge where Out_Valid and
// Out_Ready are both high. Out_Valid never depends on Out_Ready, and once it
// is raised Out_Data/Out_Idx/Out_Last stay stable until the beat transfers;
// only an Abort flush may withdraw a pending beat.
// Modports: master = reader side, slave = memory/downstream side.
interface mem_burst_reader_if
  import mem_burst_reader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic [ADDR_W-1:0] Address;
  logic              MemRead;
  logic [DATA_W-1:0] ReadData;
  logic              Out_Valid;
  logic              Out_Ready;
  logic [DATA_W-1:0] Out_Data;
  logic [ADDR_W-1:0] Out_Idx;
  logic              Out_Last;

  modport master (
    output Address, MemRead, Out_Valid, Out_Data, Out_Idx, Out_Last,
    input  ReadData, Out_Ready
  );

  modport slave (
    input  Address, MemRead, Out_Valid, Out_Data, Out_Idx, Out_Last,
    output ReadData, Out_Ready
  );

endinterface

// File: rtl/mem_burst_reader_sync_fifo.sv
// Synchronous FIFO with registered storage, reusable across bank readers.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (storage cleared to 0)
//   flush      : synchronous empty; overrides push/pop
//   push, wr_data : write request and data; accepted when not full, or when
//                   full and a pop happens in the same cycle
//   pop        : remove head (ignored when empty)
//   rd_data    : head entry (combinational from storage)
//   full, empty, count : occupancy status
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module mem_burst_reader_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush) mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/mem_burst_reader.sv
// Read-side burst sequencer for one data-memory bank.
// On Start (in IDLE) it sweeps Len bytes from Base (wrapping modulo 2^ADDR_W,
// Len=0 meaning 2^ADDR_W), captures each byte in the cycle it is addressed and
// streams {data, idx, last} through a small FIFO to the downstream stage.
// Ports:
//   Clk, Rst_n  : clock, asynchronous active-low reset
//   Start       : one-cycle command, honoured only in IDLE
//   Base, Len   : window start and byte count, sampled on an accepted Start
//   Abort       : synchronous flush back to IDLE, no Done
//   Busy        : high in every state except IDLE
//   Done        : one-cycle pulse after the last byte is taken downstream
//   Dbg_State   : current sequencer state
//   bus         : memory port and output stream (see mem_burst_reader_if)
module mem_burst_reader
  import mem_burst_reader_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Start,
  input  logic [ADDR_W-1:0]  Base,
  input  logic [ADDR_W-1:0]  Len,
  input  logic               Abort,
  output logic               Busy,
  output logic               Done,
  output state_e             Dbg_State,
  mem_burst_reader_if.master bus
);

  localparam int REM_W = ADDR_W + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] idx;
    logic              last;
  } entry_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [REM_W-1:0]  remaining_q, remaining_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  logic              mem_read;
  logic              out_valid;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  entry_t            wr_entry;
  entry_t            rd_entry;

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & bus.Out_Ready;

  assign wr_entry.data = bus.ReadData;
  assign wr_entry.idx  = idx_q;
  assign wr_entry.last = (remaining_q == REM_W'(1));

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    mem_read    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          cur_addr_d  = Base;
          // Len=0 stands for a full sweep of the address space.
          remaining_d = (Len == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, Len};
          idx_d       = '0;
          state_d     = READ;
        end
      end
      READ: begin
        // Read only when the captured byte has a slot to land in this cycle,
        // so a stalled stream leaves the address and memory untouched.
        mem_read = ~fifo_full | pop;
        if (mem_read) begin
          cur_addr_d  = cur_addr_q + ADDR_W'(1);
          idx_d       = idx_q + ADDR_W'(1);
          remaining_d = remaining_q - REM_W'(1);
          if (remaining_q == REM_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty || (pop && (fifo_count == CNT_W'(1)))) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort outranks everything, including a Start in the same cycle.
    if (Abort) begin
      state_d     = IDLE;
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;
      idx_d       = idx_q;
      mem_read    = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
    end
  end

  mem_burst_reader_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .flush   (Abort),
    .push    (mem_read),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign bus.Address   = cur_addr_q;
  assign bus.MemRead   = mem_read;
  assign bus.Out_Valid = out_valid;
  assign bus.Out_Data  = rd_entry.data;
  assign bus.Out_Idx   = rd_entry.idx;
  assign bus.Out_Last  = rd_entry.last;

  assign Busy      = (state_q != IDLE);
  assign Done      = (state_q == DONE);
  assign Dbg_State = state_q;

endmodule

// File: tb/tb_mem_burst_reader.sv
// Bench for mem_burst_reader: memory model mem[a] = a ^ 8'hA5, table-driven
// bursts plus hand-written backpressure, abort, reset and busy-start sequences.
module tb_mem_burst_reader;
  import mem_burst_reader_pkg::*;

  // ---------------- clock / reset ----------------
  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       Start;
  logic [7:0] Base;
  logic [7:0] Len;
  logic       Abort;
  logic       Busy;
  logic       Done;
  state_e     Dbg_State;

  always #5 Clk = ~Clk;

  mem_burst_reader_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  // Combinational memory bank, read gated by MemRead.
  assign bus.ReadData = bus.MemRead ? (bus.Address ^ 8'hA5) : 8'h00;

  mem_burst_reader #(
    .ADDR_W     (8),
    .DATA_W     (8),
    .FIFO_DEPTH (2)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Start     (Start),
    .Base      (Base),
    .Len       (Len),
    .Abort     (Abort),
    .Busy      (Busy),
    .Done      (Done),
    .Dbg_State (Dbg_State),
    .bus       (bus)
  );

  // ---------------- scoreboard / monitor state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          rd_cnt, done_cnt, pop_cnt;
  int          first_pop_cyc, last_pop_cyc, done_cyc, start_cyc;
  logic [7:0]  first_pop_d, last_pop_d, last_addr;
  int          addr_hits [256];
  logic [16:0] exp_q [$];

  typedef struct {
    logic [7:0] base;
    logic [7:0] len;
    int         n;
    logic [7:0] first_d;
    logic [7:0] last_d;
    logic [7:0] last_a;
  } vec_t;

  localparam int NV = 5;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic clear_mon();
    rd_cnt = 0; done_cnt = 0; pop_cnt = 0;
    first_pop_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
    first_pop_d = 8'h00; last_pop_d = 8'h00; last_addr = 8'h00;
    for (int i = 0; i < 256; i++) addr_hits[i] = 0;
  endtask

  // Expected stream for a window: data = addr ^ A5, idx 0..n-1, last on n-1.
  task automatic push_exp(input logic [7:0] b, input logic [7:0] l);
    int n;
    logic [7:0] a;
    n = (l == 8'h00) ? 256 : int'(l);
    for (int i = 0; i < n; i++) begin
      a = b + 8'(i);
      exp_q.push_back({a ^ 8'hA5, 8'(i), (i == n - 1)});
    end
  endtask

  // Observes the cycle whose closing edge will act on the inputs just driven.
  task automatic sample();
    logic [16:0] got;
    logic [16:0] want;
    if (bus.MemRead) begin
      rd_cnt++;
      addr_hits[bus.Address]++;
      last_addr = bus.Address;
    end
    if (Done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.Out_Valid && bus.Out_Ready) begin
      got = {bus.Out_Data, bus.Out_Idx, bus.Out_Last};
      if (pop_cnt == 0) begin
        first_pop_cyc = cyc;
        first_pop_d   = bus.Out_Data;
      end
      pop_cnt++;
      last_pop_cyc = cyc;
      last_pop_d   = bus.Out_Data;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL pop_unexpected actual=%0h required=none (cycle %0d)", got, cyc);
      end else begin
        want = exp_q.pop_front();
        chk("pop", 32'(got), 32'(want));
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic st, input logic [7:0] b, input logic [7:0] l,
                       input logic rdy, input logic ab);
    @(negedge Clk);
    Start = st; Base = b; Len = l; bus.Out_Ready = rdy; Abort = ab;
    cyc++;
    #1;
    sample();
  endtask

  task automatic idle_drive(input logic rdy);
    drive(1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), rdy, 1'b0);
  endtask

  // mode 0: ready held high; mode 1: ready toggles 1/0.
  task automatic run_until_done(input int budget, input int mode);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      idle_drive((mode == 0) ? 1'b1 : ((k % 2) == 0));
      k++;
    end
  endtask

  task automatic check_addr_once(input int n);
    int ones, multi;
    ones = 0; multi = 0;
    for (int i = 0; i < 256; i++) begin
      if (addr_hits[i] == 1) ones++;
      if (addr_hits[i] > 1) multi++;
    end
    chk("addr_once", 32'(ones), 32'(n));
    chk("addr_multi", 32'(multi), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    tbl[0] = '{8'h10, 8'h04, 4,   8'hB5, 8'hB6, 8'h13};
    tbl[1] = '{8'hFE, 8'h03, 3,   8'h5B, 8'hA5, 8'h00};
    tbl[2] = '{8'h00, 8'h00, 256, 8'hA5, 8'h5A, 8'hFF};
    tbl[3] = '{8'h80, 8'h01, 1,   8'h25, 8'h25, 8'h80};
    tbl[4] = '{8'h7F, 8'h02, 2,   8'hDA, 8'h25, 8'h80};

    Rst_n = 1'b0; Start = 1'b0; Base = 8'h00; Len = 8'h00; Abort = 1'b0;
    bus.Out_Ready = 1'b0;
    clear_mon();
    #1;
    chk("reset_outputs",
        32'({bus.Address, bus.MemRead, bus.Out_Valid, bus.Out_Data, bus.Out_Idx,
             bus.Out_Last, Busy, Done}), 32'd0);
    chk("reset_state", 32'(Dbg_State), 32'(IDLE));
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Table-driven bursts with ready held high.
    for (int v = 0; v < NV; v++) begin
      clear_mon();
      push_exp(tbl[v].base, tbl[v].len);
      drive(1'b1, tbl[v].base, tbl[v].len, 1'b1, 1'b0);
      start_cyc = cyc;
      chk("busy_before_accept", 32'(Busy), 32'd0);
      run_until_done(300, 0);
      idle_drive(1'b1);
      chk("done_cnt", 32'(done_cnt), 32'd1);
      chk("done_low_after", 32'({Busy, Done}), 32'd0);
      chk("reads", 32'(rd_cnt), 32'(tbl[v].n));
      chk("pops", 32'(pop_cnt), 32'(tbl[v].n));
      chk("latency", 32'(first_pop_cyc - start_cyc), 32'd2);
      chk("no_bubbles", 32'(last_pop_cyc - first_pop_cyc), 32'(tbl[v].n - 1));
      chk("done_after_last", 32'(done_cyc - last_pop_cyc), 32'd1);
      chk("first_data", 32'(first_pop_d), 32'(tbl[v].first_d));
      chk("last_data", 32'(last_pop_d), 32'(tbl[v].last_d));
      chk("last_addr", 32'(last_addr), 32'(tbl[v].last_a));
      check_addr_once(tbl[v].n);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);
    end

    // Backpressure: stall 10 cycles, then toggle ready.
    clear_mon();
    push_exp(8'h00, 8'h06);
    drive(1'b1, 8'h00, 8'h06, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      idle_drive(1'b0);
      if (i >= 2) chk("stall_hold_data", 32'({bus.Out_Valid, bus.Out_Data}), 32'h1A5);
    end
    chk("stall_reads", 32'(rd_cnt), 32'd2);
    chk("stall_addr", 32'({bus.Address, bus.MemRead}), 32'({8'h02, 1'b0}));
    chk("stall_pops", 32'(pop_cnt), 32'd0);
    run_until_done(100, 1);
    idle_drive(1'b1);
    chk("bp_done_cnt", 32'(done_cnt), 32'd1);
    chk("bp_reads", 32'(rd_cnt), 32'd6);
    chk("bp_pops", 32'(pop_cnt), 32'd6);
    chk("bp_last_data", 32'(last_pop_d), 32'hA0);
    chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    // Abort during READ after two pops.
    clear_mon();
    push_exp(8'h40, 8'h08);
    drive(1'b1, 8'h40, 8'h08, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) idle_drive(1'b1);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("abort_pops", 32'(pop_cnt), 32'd2);
    idle_drive(1'b1);
    chk("abort_idle", 32'({Busy, bus.Out_Valid, bus.MemRead}), 32'd0);
    for (int i = 0; i < 3; i++) idle_drive(1'b1);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    exp_q.delete();

    // Abort coinciding with Start in IDLE: Start is dropped.
    clear_mon();
    drive(1'b1, 8'h60, 8'h02, 1'b1, 1'b1);
    idle_drive(1'b1);
    idle_drive(1'b1);
    chk("abort_start_busy", 32'(Busy), 32'd0);
    chk("abort_start_reads", 32'(rd_cnt), 32'd0);

    // Single byte burst after abort.
    clear_mon();
    push_exp(8'h20, 8'h01);
    drive(1'b1, 8'h20, 8'h01, 1'b1, 1'b0);
    run_until_done(20, 0);
    idle_drive(1'b1);
    chk("single_data", 32'(first_pop_d), 32'h85);
    chk("single_pops", 32'(pop_cnt), 32'd1);
    chk("single_done", 32'(done_cnt), 32'd1);
    chk("single_sb_empty", 32'(exp_q.size()), 32'd0);

    // Start while busy is ignored.
    clear_mon();
    push_exp(8'h50, 8'h03);
    drive(1'b1, 8'h50, 8'h03, 1'b1, 1'b0);
    drive(1'b1, 8'h90, 8'h05, 1'b1, 1'b0);
    run_until_done(40, 0);
    idle_drive(1'b1);
    chk("busy_start_reads", 32'(rd_cnt), 32'd3);
    chk("busy_start_last_addr", 32'(last_addr), 32'h52);
    chk("busy_start_done", 32'(done_cnt), 32'd1);
    chk("busy_start_sb_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset between edges, mid-burst.
    clear_mon();
    push_exp(8'h30, 8'h08);
    drive(1'b1, 8'h30, 8'h08, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) idle_drive(1'b1);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        32'({bus.Address, bus.MemRead, bus.Out_Valid, bus.Out_Data, bus.Out_Idx,
             bus.Out_Last, Busy, Done}), 32'd0);
    chk("async_reset_state", 32'(Dbg_State), 32'(IDLE));
    @(negedge Clk);
    Rst_n = 1'b1;
    exp_q.delete();

    // Recovery burst after reset.
    clear_mon();
    push_exp(8'hC0, 8'h02);
    drive(1'b1, 8'hC0, 8'h02, 1'b1, 1'b0);
    run_until_done(20, 0);
    idle_drive(1'b1);
    chk("recover_done", 32'(done_cnt), 32'd1);
    chk("recover_last_data", 32'(last_pop_d), 32'h64);
    chk("recover_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
